pc_request_unit: RTL

Fetch/request stage of the single-cycle MIPS datapath: owns the PC register, drives instruction and data memory requests, and sequences each instruction through an instruction phase and an optional data phase. It sits directly upstream of the control unit. It supplies the fetched instruction's PC, and it consumes the control unit's `Jumps`/`BNE`/`dREN`/`dWEN`/`halt` decode together with the ALU zero flag and register-file `rdat1` to compute next-PC. `instr_done` gates register-file writes in the datapath.

---
 rtl/pc_request_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_request_unit.sv
// Fetch/request stage: owns the PC, issues instruction and data memory
// requests, and walks each instruction through FETCH and an optional DATA
// phase before committing it with a one-cycle instr_done pulse.
module pc_request_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [1:0]  Jumps,
  input  logic        BNE,
  input  logic        zero,
  input  logic [15:0] instr_imm,
  input  logic [25:0] instr_imm_26,
  input  logic [31:0] rdat1,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        halt,
  output logic [31:0] imemaddr,
  output logic [31:0] pc_plus4,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_JR     = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        branch_taken;

  assign imemaddr = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection from the control unit's decode; all sums wrap modulo 2^32.
  always_comb begin
    branch_off   = {{14{instr_imm[15]}}, instr_imm, 2'b00};
    branch_taken = zero ^ BNE;
    next_pc      = pc_plus4;
    case (pc_sel_t'(Jumps))
      PC_SEQ:    next_pc = pc_plus4;
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr_imm_26, 2'b00};
      PC_JR:     next_pc = rdat1;
      PC_BRANCH: next_pc = branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

  // Phase sequencing: next state, PC update and request/commit outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    imemREN    = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt) begin
            // HALT wins over any memory decode on the same word.
            state_d    = HALTED;
            instr_done = 1'b1;
          end else if (dREN || dWEN) begin
            // PC holds so the instruction word and decode stay stable in DATA.
            state_d = DATA;
          end else begin
            pc_d       = next_pc;
            instr_done = 1'b1;
          end
        end
      end
      DATA: begin
        dmemREN = dREN;
        dmemWEN = dWEN;
        if (dhit) begin
          pc_d       = next_pc;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and PC registers; reset is asynchronous so pending requests drop at once.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule
